// File: rtl/phys_reg_ready_table_pkg.sv
// ----------------------------------------------------------------------------
// phys_reg_ready_table_pkg
// Shared types and constants for the physical register ready table:
//   PHYS_REGS   - number of physical registers tracked
//   PHYS_ADDR_W - width of a physical register address
//   phys_addr_t - physical register address type
//   phys_onehot - decodes a physical address into a one-hot table vector
// ----------------------------------------------------------------------------
package phys_reg_ready_table_pkg;

    localparam int PHYS_REGS   = 64;
    localparam int PHYS_ADDR_W = 6;

    typedef logic [PHYS_ADDR_W-1:0] phys_addr_t;

    // One-hot decode of a physical address, used to build per-bit set/clear vectors.
    function automatic logic [PHYS_REGS-1:0] phys_onehot(input phys_addr_t addr);
        logic [PHYS_REGS-1:0] vec;
        vec       = {PHYS_REGS{1'b0}};
        vec[addr] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/phys_reg_ready_table_if.sv
// ----------------------------------------------------------------------------
// phys_reg_ready_table_if
// Bundles the rename/decode, recovery, writeback and issue signals of the
// ready table.
//   master : pipeline side, drives decode/rollback/revert/writeback, reads issue
//   slave  : ready table side
// ----------------------------------------------------------------------------
interface phys_reg_ready_table_if
    import phys_reg_ready_table_pkg::*;
#(
    parameter int READ_PORTS   = 2,
    parameter int NUM_WB_PORTS = 2
) ();

    logic                               fetch_flush;
    logic                               decode_advance;
    logic                               decode_uses_rd;
    phys_addr_t                         decode_phys_rd_addr;
    phys_addr_t [READ_PORTS-1:0]        decode_phys_rs_addr;
    logic                               rollback;
    phys_addr_t                         rollback_phys_addr;
    logic                               revert;
    phys_addr_t                         revert_phys_addr;
    logic       [NUM_WB_PORTS-1:0]      wb_valid;
    phys_addr_t [NUM_WB_PORTS-1:0]      wb_phys_addr;
    phys_addr_t [READ_PORTS-1:0]        issue_phys_rs_addr;
    logic       [READ_PORTS-1:0]        issue_rs_ready;

    modport master (
        output fetch_flush, decode_advance, decode_uses_rd, decode_phys_rd_addr,
               decode_phys_rs_addr, rollback, rollback_phys_addr, revert,
               revert_phys_addr, wb_valid, wb_phys_addr,
        input  issue_phys_rs_addr, issue_rs_ready
    );

    modport slave (
        input  fetch_flush, decode_advance, decode_uses_rd, decode_phys_rd_addr,
               decode_phys_rs_addr, rollback, rollback_phys_addr, revert,
               revert_phys_addr, wb_valid, wb_phys_addr,
        output issue_phys_rs_addr, issue_rs_ready
    );

endinterface

// File: rtl/phys_reg_ready_table_wb_addr_match.sv
// ----------------------------------------------------------------------------
// phys_reg_ready_table_wb_addr_match
// Compares one lookup address against every writeback port.
//   wb_valid     in  NUM_WB_PORTS     writeback strobes
//   wb_phys_addr in  NUM_WB_PORTS*6   writeback addresses
//   lookup_addr  in  6                address being looked up
//   hit          out NUM_WB_PORTS     per-port match (valid & address equal)
// ----------------------------------------------------------------------------
module phys_reg_ready_table_wb_addr_match
    import phys_reg_ready_table_pkg::*;
#(
    parameter int NUM_WB_PORTS = 2
) (
    input  logic       [NUM_WB_PORTS-1:0] wb_valid,
    input  phys_addr_t [NUM_WB_PORTS-1:0] wb_phys_addr,
    input  phys_addr_t                    lookup_addr,
    output logic       [NUM_WB_PORTS-1:0] hit
);

    // Per-port comparator.
    always_comb begin
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            hit[p] = wb_valid[p] & (wb_phys_addr[p] == lookup_addr);
        end
    end

endmodule

// File: rtl/phys_reg_ready_table.sv
// ----------------------------------------------------------------------------
// phys_reg_ready_table
// Tracks, for each physical register, whether its value has been written
// back. Rename clears the bit of a newly allocated rd; writeback, rollback and
// revert set bits. Source operands are looked up at decode (with same-cycle
// writeback forwarding), registered into issue on decode_advance, and kept
// current from writeback while the instruction waits in issue.
//   clk  in  clock
//   rst  in  synchronous active-high reset (all registers ready)
//   bus  slave modport of phys_reg_ready_table_if (decode, recovery,
//        writeback inputs; issue_phys_rs_addr / issue_rs_ready outputs)
// ----------------------------------------------------------------------------
module phys_reg_ready_table
    import phys_reg_ready_table_pkg::*;
#(
    parameter int READ_PORTS   = 2,
    parameter int NUM_WB_PORTS = 2,
    parameter int RENAME_ZERO  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    phys_reg_ready_table_if.slave bus
);

    logic [PHYS_REGS-1:0]       ready_r;
    logic [PHYS_REGS-1:0]       ready_view_s;
    logic [PHYS_REGS-1:0]       set_vec_s;
    logic [PHYS_REGS-1:0]       clr_vec_s;
    logic                       mark_s;

    logic [NUM_WB_PORTS-1:0]    dec_hit_s [READ_PORTS];
    logic [NUM_WB_PORTS-1:0]    iss_hit_s [READ_PORTS];
    logic [READ_PORTS-1:0]      fwd_ready_s;
    logic [READ_PORTS-1:0]      hold_set_s;

    phys_addr_t [READ_PORTS-1:0] issue_phys_rs_addr_r;
    logic       [READ_PORTS-1:0] issue_rs_ready_r;

    // Rename clears the new rd unless the cycle is flushed; reg 0 only when it is tracked.
    always_comb begin
        mark_s = bus.decode_advance & ~bus.fetch_flush & bus.decode_uses_rd &
                 ((RENAME_ZERO != 0) || (bus.decode_phys_rd_addr != 6'd0));
    end

    // Per-bit set/clear vectors; set sources are writeback, rollback and revert.
    always_comb begin
        set_vec_s = {PHYS_REGS{1'b0}};
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            if (bus.wb_valid[p]) begin
                set_vec_s = set_vec_s | phys_onehot(bus.wb_phys_addr[p]);
            end else begin
                set_vec_s = set_vec_s;
            end
        end
        if (bus.rollback) begin
            set_vec_s = set_vec_s | phys_onehot(bus.rollback_phys_addr);
        end else begin
            set_vec_s = set_vec_s;
        end
        if (bus.revert) begin
            set_vec_s = set_vec_s | phys_onehot(bus.revert_phys_addr);
        end else begin
            set_vec_s = set_vec_s;
        end
        if (mark_s) begin
            clr_vec_s = phys_onehot(bus.decode_phys_rd_addr);
        end else begin
            clr_vec_s = {PHYS_REGS{1'b0}};
        end
    end

    // Ready table update; clear is applied after set so a rename mark wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r <= {PHYS_REGS{1'b1}};
        end else begin
            ready_r <= (ready_r | set_vec_s) & ~clr_vec_s;
        end
    end

    // Reg 0 reads ready when it is not renamed.
    always_comb begin
        ready_view_s = ready_r;
        if (RENAME_ZERO == 0) begin
            ready_view_s[0] = 1'b1;
        end else begin
            ready_view_s[0] = ready_r[0];
        end
    end

    // Writeback comparators: one set for the decode lookup, one for the held issue operands.
    for (genvar i = 0; i < READ_PORTS; i++) begin : g_read_port
        phys_reg_ready_table_wb_addr_match #(
            .NUM_WB_PORTS (NUM_WB_PORTS)
        ) u_dec_match (
            .wb_valid     (bus.wb_valid),
            .wb_phys_addr (bus.wb_phys_addr),
            .lookup_addr  (bus.decode_phys_rs_addr[i]),
            .hit          (dec_hit_s[i])
        );

        phys_reg_ready_table_wb_addr_match #(
            .NUM_WB_PORTS (NUM_WB_PORTS)
        ) u_iss_match (
            .wb_valid     (bus.wb_valid),
            .wb_phys_addr (bus.wb_phys_addr),
            .lookup_addr  (issue_phys_rs_addr_r[i]),
            .hit          (iss_hit_s[i])
        );
    end

    // Decode lookup sees the table before this cycle's mark, plus forwarded writebacks.
    always_comb begin
        for (int i = 0; i < READ_PORTS; i++) begin
            fwd_ready_s[i] = ready_view_s[bus.decode_phys_rs_addr[i]] | (|dec_hit_s[i]);
            hold_set_s[i]  = |iss_hit_s[i];
        end
    end

    // Issue register: load on advance, otherwise accumulate writebacks (never drops).
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_phys_rs_addr_r <= {(READ_PORTS*PHYS_ADDR_W){1'b0}};
            issue_rs_ready_r     <= {READ_PORTS{1'b1}};
        end else if (bus.decode_advance) begin
            issue_phys_rs_addr_r <= bus.decode_phys_rs_addr;
            issue_rs_ready_r     <= fwd_ready_s;
        end else begin
            issue_phys_rs_addr_r <= issue_phys_rs_addr_r;
            issue_rs_ready_r     <= issue_rs_ready_r | hold_set_s;
        end
    end

    assign bus.issue_phys_rs_addr = issue_phys_rs_addr_r;
    assign bus.issue_rs_ready     = issue_rs_ready_r;

endmodule
